clock_enable_manager: RTL and testbench

Parametrised clock/reset manager for the platform clock tree, sitting directly behind the board PLL wrapper on `clk_system`. It synchronises the PLL lock indication and waits for a stable-lock interval. It then releases up to NUM_CHANNEL per-domain resets in a fixed staggered order. Each released domain gets a programmable divided clock-enable tick with glitch-free divisor update. On lock loss it re-asserts every reset and counts the event.

---
 rtl/clock_enable_manager.sv | 179 +++++++++++++++++
 tb/tb_clock_enable_manager.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/clock_enable_manager.sv
// Lock-qualified reset sequencer with per-domain divided clock-enable ticks.
// state        | meaning
// WAIT_LOCK    | all domain resets held, waiting for synchronised lock
// STABILIZE    | lock seen, counting the stable-lock interval
// RELEASE      | releasing domain resets one by one, RELEASE_GAP apart
// RUN          | all domains out of reset, system_ready high
module clock_enable_manager #(
  parameter int NUM_CHANNEL        = 4,
  parameter int DIV_WIDTH          = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RELEASE_GAP        = 16
) (
  input  logic                             clk_system,
  input  logic                             rst_system,
  input  logic                             pll_locked,
  input  logic [NUM_CHANNEL*DIV_WIDTH-1:0] div_value,
  input  logic                             div_update,
  output logic [NUM_CHANNEL-1:0]           tick,
  output logic [NUM_CHANNEL-1:0]           rstnn_channel,
  output logic                             system_ready,
  output logic [7:0]                       lock_loss_count
);

  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int GW = $clog2(RELEASE_GAP + 1);
  localparam int CW = $clog2(NUM_CHANNEL + 1);

  typedef enum logic [1:0] {ST_WAIT_LOCK, ST_STABILIZE, ST_RELEASE, ST_RUN} state_t;

  logic                   sync1_q, locked_sync_q;
  state_t                 state_q, state_d;
  logic [SW-1:0]          stab_q, stab_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [CW-1:0]          ch_q, ch_d;
  logic [NUM_CHANNEL-1:0] rstnn_q, rstnn_d;
  logic                   ready_q, ready_d;
  logic [7:0]             loss_q, loss_d;

  logic [DIV_WIDTH-1:0]   shadow_q [NUM_CHANNEL];
  logic [DIV_WIDTH-1:0]   shadow_d [NUM_CHANNEL];
  logic [DIV_WIDTH-1:0]   cnt_q    [NUM_CHANNEL];
  logic [DIV_WIDTH-1:0]   cnt_d    [NUM_CHANNEL];
  logic [DIV_WIDTH-1:0]   pend_q   [NUM_CHANNEL];
  logic [DIV_WIDTH-1:0]   pend_d   [NUM_CHANNEL];
  logic [NUM_CHANNEL-1:0] pv_q, pv_d;
  logic [NUM_CHANNEL-1:0] tick_q, tick_d;

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    gap_d   = gap_q;
    ch_d    = ch_q;
    rstnn_d = rstnn_q;
    ready_d = ready_q;
    loss_d  = loss_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        rstnn_d = '0;
        ready_d = 1'b0;
        if (locked_sync_q) begin
          state_d = ST_STABILIZE;
          stab_d  = '0;
        end
      end
      ST_STABILIZE: begin
        if (stab_q == SW'(LOCK_STABLE_CYCLES - 1)) begin
          state_d = ST_RELEASE;
          rstnn_d = NUM_CHANNEL'(1);
          gap_d   = '0;
          ch_d    = '0;
        end else begin
          stab_d = stab_q + SW'(1);
        end
      end
      ST_RELEASE: begin
        if (ch_q == CW'(NUM_CHANNEL - 1)) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end else if (gap_q == GW'(RELEASE_GAP - 1)) begin
          // releases are strictly in order, so the mask is a thermometer code
          rstnn_d = (rstnn_q << 1) | NUM_CHANNEL'(1);
          ch_d    = ch_q + CW'(1);
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: ;
    endcase
    if (state_q != ST_WAIT_LOCK && !locked_sync_q) begin
      state_d = ST_WAIT_LOCK;
      rstnn_d = '0;
      ready_d = 1'b0;
      stab_d  = '0;
      gap_d   = '0;
      ch_d    = '0;
      loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    pv_d     = pv_q;
    tick_d   = '0;
    for (int i = 0; i < NUM_CHANNEL; i++) begin
      if (!rstnn_q[i]) begin
        // a channel held in reset has no period to protect: take the new divisor now
        if (div_update) begin
          shadow_d[i] = div_value[i*DIV_WIDTH +: DIV_WIDTH];
        end else if (pv_q[i]) begin
          shadow_d[i] = pend_q[i];
        end
        pv_d[i]  = 1'b0;
        cnt_d[i] = '0;
      end else begin
        if (tick_q[i]) begin
          if (pv_q[i]) shadow_d[i] = pend_q[i];
          pv_d[i]  = 1'b0;
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + DIV_WIDTH'(1);
        end
        if (div_update) begin
          pend_d[i] = div_value[i*DIV_WIDTH +: DIV_WIDTH];
          pv_d[i]   = 1'b1;
        end
      end
      if (!rstnn_d[i]) begin
        cnt_d[i] = '0;
      end else begin
        tick_d[i] = (cnt_d[i] == shadow_d[i]);
      end
    end
  end

  always_ff @(posedge clk_system) begin
    if (rst_system) begin
      sync1_q       <= 1'b0;
      locked_sync_q <= 1'b0;
      state_q       <= ST_WAIT_LOCK;
      stab_q        <= '0;
      gap_q         <= '0;
      ch_q          <= '0;
      rstnn_q       <= '0;
      ready_q       <= 1'b0;
      loss_q        <= '0;
      pv_q          <= '0;
      tick_q        <= '0;
      for (int i = 0; i < NUM_CHANNEL; i++) begin
        shadow_q[i] <= div_value[i*DIV_WIDTH +: DIV_WIDTH];
        cnt_q[i]    <= '0;
        pend_q[i]   <= '0;
      end
    end else begin
      sync1_q       <= pll_locked;
      locked_sync_q <= sync1_q;
      state_q       <= state_d;
      stab_q        <= stab_d;
      gap_q         <= gap_d;
      ch_q          <= ch_d;
      rstnn_q       <= rstnn_d;
      ready_q       <= ready_d;
      loss_q        <= loss_d;
      pv_q          <= pv_d;
      tick_q        <= tick_d;
      shadow_q      <= shadow_d;
      cnt_q         <= cnt_d;
      pend_q        <= pend_d;
    end
  end

  assign tick            = tick_q;
  assign rstnn_channel   = rstnn_q;
  assign system_ready    = ready_q;
  assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_clock_enable_manager.sv
// Directed bench for clock_enable_manager: release sequencing, dividers,
// divisor update, lock loss, saturation and mid-sequence reset.
module tb_clock_enable_manager;

  logic        clk_system = 1'b0;
  logic        rst_system;
  logic        pll_locked;
  logic [63:0] div_value;
  logic        div_update;
  logic [3:0]  tick;
  logic [3:0]  rstnn_channel;
  logic        system_ready;
  logic [7:0]  lock_loss_count;

  int n_cmp  = 0;
  int n_fail = 0;

  clock_enable_manager #(
    .NUM_CHANNEL(4),
    .DIV_WIDTH(16),
    .LOCK_STABLE_CYCLES(8),
    .RELEASE_GAP(4)
  ) dut (
    .clk_system(clk_system),
    .rst_system(rst_system),
    .pll_locked(pll_locked),
    .div_value(div_value),
    .div_update(div_update),
    .tick(tick),
    .rstnn_channel(rstnn_channel),
    .system_ready(system_ready),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clk_system = ~clk_system;

  task automatic tick_edge();
    @(posedge clk_system);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // divisors 0/3/5/1 loaded at reset; releases at E10/E14/E18/E22
  function automatic logic [3:0] exp_tick(input int n);
    logic [3:0] e;
    e[0] = (n >= 10);
    e[1] = (n >= 14) && (((n - 14) % 4) == 3);
    e[2] = (n >= 18) && (((n - 18) % 6) == 5);
    e[3] = (n >= 22) && (((n - 22) % 2) == 1);
    return e;
  endfunction

  // call with pll_locked already high; the first edge is E0
  task automatic run_release(input int exp_cnt, input bit chk_ticks);
    logic [3:0] er;
    for (int n = 0; n < 24; n++) begin
      tick_edge();
      for (int k = 0; k < 4; k++) er[k] = (n >= 10 + 4 * k);
      chk("rstnn_seq", rstnn_channel, er);
      chk("ready_seq", system_ready, (n >= 23));
      if (chk_ticks) chk("tick_seq", tick, exp_tick(n));
    end
    chk("count_after_release", lock_loss_count, exp_cnt);
  endtask

  initial begin
    bit found;
    rst_system = 1'b1;
    pll_locked = 1'b0;
    div_update = 1'b0;
    div_value  = {16'd1, 16'd5, 16'd3, 16'd0};
    tick_edge();
    tick_edge();
    chk("reset_tick", tick, 4'h0);
    chk("reset_rstnn", rstnn_channel, 4'h0);
    chk("reset_ready", system_ready, 1'b0);
    chk("reset_count", lock_loss_count, 8'd0);
    rst_system = 1'b0;
    pll_locked = 1'b1;

    run_release(0, 1'b1);
    for (int n = 24; n <= 40; n++) begin
      tick_edge();
      chk("tick_run", tick, exp_tick(n));
    end

    // ch1 divisor 3 -> 9, update issued one cycle after a ch1 tick
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick_edge();
      if (tick[1]) found = 1'b1;
    end
    chk("tick1_seen", found, 1'b1);
    for (int r = 1; r <= 24; r++) begin
      tick_edge();
      if (r == 1) begin
        div_value  = {16'd1, 16'd5, 16'd9, 16'd0};
        div_update = 1'b1;
      end else if (r == 2) begin
        div_update = 1'b0;
      end
      chk("tick1_update", tick[1], (r == 4 || r == 14 || r == 24));
      chk("tick0_update", tick[0], 1'b1);
    end

    // lock drop in RUN at edge L
    pll_locked = 1'b0;
    tick_edge();
    tick_edge();
    chk("drop_l1_rstnn", rstnn_channel, 4'hF);
    chk("drop_l1_ready", system_ready, 1'b1);
    tick_edge();
    chk("drop_l2_rstnn", rstnn_channel, 4'h0);
    chk("drop_l2_tick", tick, 4'h0);
    chk("drop_l2_ready", system_ready, 1'b0);
    chk("drop_l2_count", lock_loss_count, 8'd1);
    pll_locked = 1'b1;
    run_release(1, 1'b0);

    // 5-cycle dropout during STABILIZE
    pll_locked = 1'b0;
    repeat (4) tick_edge();
    chk("count_second_loss", lock_loss_count, 8'd2);
    pll_locked = 1'b1;
    repeat (5) tick_edge();
    chk("stab_rstnn", rstnn_channel, 4'h0);
    pll_locked = 1'b0;
    repeat (5) tick_edge();
    chk("count_glitch", lock_loss_count, 8'd3);
    pll_locked = 1'b1;
    run_release(3, 1'b0);

    // saturation
    for (int it = 0; it < 260; it++) begin
      pll_locked = 1'b1;
      repeat (3) tick_edge();
      pll_locked = 1'b0;
      repeat (3) tick_edge();
      if (it == 49) chk("count_mid", lock_loss_count, 8'd53);
    end
    chk("count_saturated", lock_loss_count, 8'd255);

    // reset during RELEASE with two channels out
    pll_locked = 1'b1;
    repeat (15) tick_edge();
    chk("rel_two_out", rstnn_channel, 4'h3);
    rst_system = 1'b1;
    tick_edge();
    chk("mid_rst_tick", tick, 4'h0);
    chk("mid_rst_rstnn", rstnn_channel, 4'h0);
    chk("mid_rst_ready", system_ready, 1'b0);
    chk("mid_rst_count", lock_loss_count, 8'd0);
    rst_system = 1'b0;
    run_release(0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
